// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the saturating counter update, predictor FSM states and index modes.
package bp_pkg;

  localparam logic [1:0] SN = 2'b00;  // strongly not-taken
  localparam logic [1:0] WN = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT = 2'b10;  // weakly taken
  localparam logic [1:0] ST = 2'b11;  // strongly taken

  localparam int BP_CONCAT = 0;
  localparam int BP_GSHARE = 1;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      nxt = (cnt == SN) ? SN : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Tagged branch target buffer, direct mapped.
// Read is combinational (hit + stored target), write is synchronous.
// Ports:
//   i_clk                          clock
//   i_clr / i_clr_idx              invalidate one entry (init sweeper)
//   i_wr_en / i_wr_idx / i_wr_tag / i_wr_target   install a taken target
//   i_rd_idx / i_rd_tag            lookup index and tag to compare
//   o_hit                          entry valid and tag matches
//   o_rd_target                    stored target of the looked-up entry
module bp_btb #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 8,
  parameter int TAG_W = 24
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]  i_wr_target,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_hit,
  output logic [XLEN-1:0]  o_rd_target
);

  localparam int N_ENT = 2 ** IDX_W;

  logic             r_valid  [N_ENT];
  logic [TAG_W-1:0] r_tag    [N_ENT];
  logic [XLEN-1:0]  r_target [N_ENT];

  // Tag/target storage carries no reset; the valid bits gate every use and
  // are cleared by the sweeper before the predictor goes live.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_valid[i_clr_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

  assign o_hit       = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_target = r_target[i_rd_idx];

endmodule

// File: rtl/branch_predictor_unit.sv
// Two-level adaptive branch predictor: PHT of 2-bit counters indexed by
// PC and global history (concat or gshare), tagged BTB for targets,
// speculative global history with repair on mispredict, an init sweeper
// and resolution statistics.
//
// state   | meaning
// --------+------------------------------------------------------------
// BP_INIT | sweeping one PHT entry / BTB valid bit per cycle, not ready
// BP_RUN  | tables live, predictions and updates active until reset
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   o_ready                          tables initialised
//   i_pred_valid/_pc/_is_jump        fetch-side lookup
//   o_pred_taken/_target/_ghr        combinational prediction + history used
//   i_upd_valid/_pc/_ghr/_taken/_target/_mispredict   execute resolution
//   o_stat_total/_hit/_miss          resolved / correct / mispredicted counts
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 8,
  parameter int         GHR_W    = 2,
  parameter int         MODE     = 0,
  parameter logic [1:0] CNT_INIT = WN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_ready,
  input  logic             i_pred_valid,
  input  logic [XLEN-1:0]  i_pred_pc,
  input  logic             i_pred_is_jump,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_target,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_upd_valid,
  input  logic [XLEN-1:0]  i_upd_pc,
  input  logic [GHR_W-1:0] i_upd_ghr,
  input  logic             i_upd_taken,
  input  logic [XLEN-1:0]  i_upd_target,
  input  logic             i_upd_mispredict,
  output logic [31:0]      o_stat_total,
  output logic [31:0]      o_stat_hit,
  output logic [31:0]      o_stat_miss
);

  localparam int TAG_W = XLEN - IDX_W;
  localparam int PHT_W = (MODE == BP_CONCAT) ? IDX_W + GHR_W : IDX_W;
  localparam int PHT_N = 2 ** PHT_W;

  bp_state_e        r_state;
  bp_state_e        w_state_nxt;
  logic [PHT_W-1:0] r_sweep;
  logic [GHR_W-1:0] r_ghr;
  logic [1:0]       r_pht [PHT_N];
  logic [31:0]      r_stat_total;
  logic [31:0]      r_stat_hit;
  logic [31:0]      r_stat_miss;

  logic             w_run;
  logic             w_sweep_last;
  logic             w_upd_en;
  logic             w_repair;
  logic             w_spec;
  logic             w_btb_hit;
  logic [XLEN-1:0]  w_btb_target;
  logic [XLEN-1:0]  w_seq_pc;
  logic [PHT_W-1:0] w_pidx;
  logic [PHT_W-1:0] w_uidx;
  logic [GHR_W-1:0] w_ghr_spec;
  logic [GHR_W-1:0] w_ghr_repair;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= BP_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BP_INIT: if (w_sweep_last) w_state_nxt = BP_RUN;
      BP_RUN:  w_state_nxt = BP_RUN;
      default: w_state_nxt = BP_INIT;
    endcase
  end

  assign w_run   = (r_state == BP_RUN);
  assign o_ready = w_run;

  // Sweep walks every PHT entry once; the BTB uses the low bits, which
  // cover all BTB entries since PHT_W >= IDX_W.
  assign w_sweep_last = &r_sweep;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sweep <= '0;
    end else if (!w_run) begin
      r_sweep <= r_sweep + PHT_W'(1);
    end
  end

  // -------------------------------------------------------- PHT indexing
  generate
    if (MODE == BP_CONCAT) begin : g_concat
      assign w_pidx = {i_pred_pc[IDX_W-1:0], r_ghr};
      assign w_uidx = {i_upd_pc[IDX_W-1:0], i_upd_ghr};
    end else begin : g_gshare
      assign w_pidx = i_pred_pc[IDX_W-1:0] ^ IDX_W'(r_ghr);
      assign w_uidx = i_upd_pc[IDX_W-1:0] ^ IDX_W'(i_upd_ghr);
    end
  endgenerate

  // ------------------------------------------------------ history shifts
  generate
    if (GHR_W == 1) begin : g_ghr1
      assign w_ghr_spec   = o_pred_taken;
      assign w_ghr_repair = i_upd_taken;
    end else begin : g_ghrn
      assign w_ghr_spec   = {r_ghr[GHR_W-2:0], o_pred_taken};
      assign w_ghr_repair = {i_upd_ghr[GHR_W-2:0], i_upd_taken};
    end
  endgenerate

  // ------------------------------------------------------------- BTB
  bp_btb #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .i_clk       (i_clk),
    .i_clr       (!w_run),
    .i_clr_idx   (r_sweep[IDX_W-1:0]),
    .i_wr_en     (w_upd_en && i_upd_taken),
    .i_wr_idx    (i_upd_pc[IDX_W-1:0]),
    .i_wr_tag    (i_upd_pc[XLEN-1:IDX_W]),
    .i_wr_target (i_upd_target),
    .i_rd_idx    (i_pred_pc[IDX_W-1:0]),
    .i_rd_tag    (i_pred_pc[XLEN-1:IDX_W]),
    .o_hit       (w_btb_hit),
    .o_rd_target (w_btb_target)
  );

  // ------------------------------------------------------- prediction
  assign w_seq_pc      = i_pred_pc + XLEN'(1);
  assign o_pred_taken  = w_run && i_pred_is_jump && r_pht[w_pidx][1] && w_btb_hit;
  assign o_pred_target = o_pred_taken ? w_btb_target : w_seq_pc;
  assign o_pred_ghr    = r_ghr;

  // Resolution and speculation are both inert until the tables are swept.
  assign w_upd_en = w_run && i_upd_valid;
  assign w_repair = w_upd_en && i_upd_mispredict;
  assign w_spec   = w_run && i_pred_valid && i_pred_is_jump;

  // Repair wins: a mispredict flushes whatever fetch is looking at now.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if (w_repair) begin
      r_ghr <= w_ghr_repair;
    end else if (w_spec) begin
      r_ghr <= w_ghr_spec;
    end
  end

  // PHT has no reset of its own; the sweeper rewrites it after every reset.
  always_ff @(posedge i_clk) begin
    if (!w_run) begin
      r_pht[r_sweep] <= CNT_INIT;
    end else if (i_upd_valid) begin
      r_pht[w_uidx] <= sat_next(r_pht[w_uidx], i_upd_taken);
    end
  end

  // ------------------------------------------------------------ stats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_total <= '0;
      r_stat_hit   <= '0;
      r_stat_miss  <= '0;
    end else if (w_upd_en) begin
      r_stat_total <= r_stat_total + 32'd1;
      if (i_upd_mispredict) begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end else begin
        r_stat_hit <= r_stat_hit + 32'd1;
      end
    end
  end

  assign o_stat_total = r_stat_total;
  assign o_stat_hit   = r_stat_hit;
  assign o_stat_miss  = r_stat_miss;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: one concat-indexed and one gshare-indexed
// instance share the same stimulus; a table-level model of each predictor
// is stepped at every posedge and compared against both at every negedge.
module tb_branch_predictor_unit;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_is_jump;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_ghr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        rdy0, tk0, rdy1, tk1;
  logic [31:0] tgt0, tgt1, tot0, tot1, hit0, hit1, miss0, miss1;
  logic [1:0]  gh0, gh1;

  int checks;
  int failures;
  bit chk_en;

  branch_predictor_unit #(.MODE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .o_ready(rdy0),
    .i_pred_valid(pred_valid), .i_pred_pc(pred_pc), .i_pred_is_jump(pred_is_jump),
    .o_pred_taken(tk0), .o_pred_target(tgt0), .o_pred_ghr(gh0),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_ghr(upd_ghr),
    .i_upd_taken(upd_taken), .i_upd_target(upd_target), .i_upd_mispredict(upd_mispredict),
    .o_stat_total(tot0), .o_stat_hit(hit0), .o_stat_miss(miss0)
  );

  branch_predictor_unit #(.MODE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .o_ready(rdy1),
    .i_pred_valid(pred_valid), .i_pred_pc(pred_pc), .i_pred_is_jump(pred_is_jump),
    .o_pred_taken(tk1), .o_pred_target(tgt1), .o_pred_ghr(gh1),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_ghr(upd_ghr),
    .i_upd_taken(upd_taken), .i_upd_target(upd_target), .i_upd_mispredict(upd_mispredict),
    .o_stat_total(tot1), .o_stat_hit(hit1), .o_stat_miss(miss1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int          m_cnt   [2][1024];
  bit          m_bv    [2][256];
  logic [23:0] m_btag  [2][256];
  logic [31:0] m_btgt  [2][256];
  int          m_ghr   [2];
  int          m_left  [2];
  logic [31:0] m_tot   [2];
  logic [31:0] m_hit   [2];
  logic [31:0] m_miss  [2];

  function automatic int pidx(input int m, input logic [31:0] pc, input int g);
    int lo;
    lo = int'(pc[7:0]);
    return (m == 0) ? lo * 4 + g : lo ^ g;
  endfunction

  function automatic void model_pred(input int m, input logic [31:0] pc, input logic isj,
                                     output logic tk, output logic [31:0] tgt);
    int  b;
    bit  hit;
    tk  = 1'b0;
    tgt = pc + 32'd1;
    if (m_left[m] == 0) begin
      b   = int'(pc[7:0]);
      hit = m_bv[m][b] && (m_btag[m][b] == pc[31:8]);
      tk  = isj && hit && (m_cnt[m][pidx(m, pc, m_ghr[m])] >= 2);
      if (tk) tgt = m_btgt[m][b];
    end
  endfunction

  function automatic void model_step(input int m);
    logic        tk;
    logic [31:0] tgt;
    int          ui;
    int          b;
    if (rst) begin
      m_left[m] = (m == 0) ? 1024 : 256;
      m_ghr[m]  = 0;
      m_tot[m]  = 0;
      m_hit[m]  = 0;
      m_miss[m] = 0;
      for (int i = 0; i < 1024; i++) m_cnt[m][i] = 1;
      for (int i = 0; i < 256; i++) m_bv[m][i] = 1'b0;
      return;
    end
    if (m_left[m] > 0) begin
      m_left[m]--;
      return;
    end
    model_pred(m, pred_pc, pred_is_jump, tk, tgt);
    if (upd_valid) begin
      ui = pidx(m, upd_pc, int'(upd_ghr));
      if (upd_taken) m_cnt[m][ui] = (m_cnt[m][ui] < 3) ? m_cnt[m][ui] + 1 : 3;
      else           m_cnt[m][ui] = (m_cnt[m][ui] > 0) ? m_cnt[m][ui] - 1 : 0;
      if (upd_taken) begin
        b = int'(upd_pc[7:0]);
        m_bv[m][b]   = 1'b1;
        m_btag[m][b] = upd_pc[31:8];
        m_btgt[m][b] = upd_target;
      end
      m_tot[m] = m_tot[m] + 32'd1;
      if (upd_mispredict) m_miss[m] = m_miss[m] + 32'd1;
      else                m_hit[m]  = m_hit[m] + 32'd1;
    end
    if (upd_valid && upd_mispredict) m_ghr[m] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 4;
    else if (pred_valid && pred_is_jump) m_ghr[m] = (m_ghr[m] * 2 + int'(tk)) % 4;
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // -------------------------------------------------------------- checking
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cmp_dut(input int m, input logic rdy, input logic tk, input logic [31:0] tgt,
                         input logic [1:0] gh, input logic [31:0] tot, input logic [31:0] hi,
                         input logic [31:0] mi);
    logic        etk;
    logic [31:0] etgt;
    model_pred(m, pred_pc, pred_is_jump, etk, etgt);
    chk($sformatf("m%0d_ready", m),  32'(rdy), 32'(m_left[m] == 0));
    chk($sformatf("m%0d_taken", m),  32'(tk),  32'(etk));
    chk($sformatf("m%0d_target", m), tgt, etgt);
    chk($sformatf("m%0d_ghr", m),    32'(gh),  32'(m_ghr[m]));
    chk($sformatf("m%0d_total", m),  tot, m_tot[m]);
    chk($sformatf("m%0d_hit", m),    hi,  m_hit[m]);
    chk($sformatf("m%0d_miss", m),   mi,  m_miss[m]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, rdy0, tk0, tgt0, gh0, tot0, hit0, miss0);
      cmp_dut(1, rdy1, tk1, tgt1, gh1, tot1, hit1, miss1);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_is_jump = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] g, input logic t,
                     input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = t;
    upd_target = tgt; upd_mispredict = mis;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    case ($urandom_range(0, 7))
      0:       pc = $urandom();
      1:       pc = 32'hFFFF_FFFF;
      default: pc = (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 7));
    endcase
    return pc;
  endfunction

  task automatic rand_upd();
    upd_valid      = ($urandom_range(0, 1) == 0);
    upd_pc         = rand_pc();
    upd_ghr        = 2'($urandom_range(0, 3));
    upd_taken      = ($urandom_range(0, 2) != 0);
    upd_target     = $urandom();
    upd_mispredict = ($urandom_range(0, 3) == 0);
  endtask

  task automatic rand_all(input bit allow_rst);
    rst          = allow_rst && ($urandom_range(0, 1999) == 0);
    pred_valid   = ($urandom_range(0, 3) != 0);
    pred_pc      = rand_pc();
    pred_is_jump = ($urandom_range(0, 3) != 0);
    rand_upd();
  endtask

  initial begin
    int  t0, t1;
    bit  got0, got1;
    checks = 0; failures = 0; chk_en = 1'b0;
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // init window: fixed fetch PC, random resolutions that must be ignored
    pred_valid = 1'b1; pred_pc = 32'h40; pred_is_jump = 1'b1;
    @(negedge clk);
    chk("init_taken0", 32'(tk0), 32'h0);
    chk("init_target0", tgt0, 32'h41);
    chk("init_taken1", 32'(tk1), 32'h0);
    chk("init_target1", tgt1, 32'h41);
    chk("init_ready0", 32'(rdy0), 32'h0);
    got0 = 1'b0; got1 = 1'b0; t0 = 0; t1 = 0;
    for (int n = 1; n <= 1100; n++) begin
      tick();
      if (n < 250) rand_upd();
      else begin upd_valid = 1'b0; pred_valid = 1'b0; end
      @(negedge clk);
      if (n == 100) chk("init_mid_target0", tgt0, 32'h41);
      if (!got0 && rdy0) begin got0 = 1'b1; t0 = n; end
      if (!got1 && rdy1) begin got1 = 1'b1; t1 = n; end
      if (got0 && got1) break;
    end
    chk("ready_cycles_mode0", t0, 32'd1024);
    chk("ready_cycles_mode1", t1, 32'd256);

    // basic train: two taken updates at pc 0x10, ghr 00
    tick();
    set_idle();
    upd(32'h10, 2'd0, 1'b1, 32'h80, 1'b0);
    tick(); tick();
    upd_valid = 1'b0; pred_pc = 32'h10; pred_is_jump = 1'b1;
    @(negedge clk);
    chk("train_taken0", 32'(tk0), 32'h1);
    chk("train_target0", tgt0, 32'h80);
    chk("train_taken1", 32'(tk1), 32'h1);
    chk("train_total0", tot0, 32'd2);

    // saturation: 3 more taken, 1 not-taken -> still taken
    tick();
    upd(32'h10, 2'd0, 1'b1, 32'h80, 1'b0);
    repeat (3) tick();
    upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("sat_weak_taken0", 32'(tk0), 32'h1);
    chk("sat_weak_taken1", 32'(tk1), 32'h1);
    tick();
    upd(32'h10, 2'd0, 1'b0, 32'h80, 1'b0);
    repeat (3) tick();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("sat_low_taken0", 32'(tk0), 32'h0);
    chk("sat_low_target0", tgt0, 32'h11);
    tick();
    upd(32'h10, 2'd0, 1'b0, 32'h80, 1'b0);
    tick();
    upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("sat_floor_taken0", 32'(tk0), 32'h0);
    chk("sat_total0", tot0, 32'd11);
    chk("sat_hit0", hit0, 32'd11);

    // tag alias
    tick();
    upd(32'h10, 2'd0, 1'b1, 32'h80, 1'b0);
    tick(); tick();
    upd_valid = 1'b0; pred_pc = 32'h110;
    @(negedge clk);
    chk("alias_taken0", 32'(tk0), 32'h0);
    chk("alias_target0", tgt0, 32'h111);
    chk("alias_target1", tgt1, 32'h111);
    tick();
    pred_pc = 32'h10;
    @(negedge clk);
    chk("alias_home_target0", tgt0, 32'h80);

    // repair
    tick();
    upd(32'h10, 2'd1, 1'b1, 32'h80, 1'b0);
    tick(); tick();
    upd_ghr = 2'd3;
    tick(); tick();
    upd_valid = 1'b0; pred_valid = 1'b1; pred_pc = 32'h10; pred_is_jump = 1'b1;
    @(negedge clk);
    chk("spec_a_ghr0", 32'(gh0), 32'd0);
    tick();
    @(negedge clk);
    chk("spec_b_ghr0", 32'(gh0), 32'd1);
    chk("spec_b_taken1", 32'(tk1), 32'h1);
    tick();
    upd(32'h55, 2'd0, 1'b0, 32'h1234, 1'b1);
    @(negedge clk);
    chk("spec_c_ghr0", 32'(gh0), 32'd3);
    tick();
    set_idle();
    @(negedge clk);
    chk("repair_ghr0", 32'(gh0), 32'd0);
    chk("repair_ghr1", 32'(gh1), 32'd0);
    chk("repair_miss0", miss0, 32'd1);

    // gshare aliasing: pc 0x03/ghr 01 and pc 0x02/ghr 00 share index 0x02
    tick();
    upd(32'h02, 2'd0, 1'b1, 32'h99, 1'b0);
    tick();
    upd_valid = 1'b0; pred_pc = 32'h02; pred_is_jump = 1'b1;
    @(negedge clk);
    chk("gs_pc2_taken1", 32'(tk1), 32'h1);
    chk("gs_pc2_target1", tgt1, 32'h99);
    tick();
    upd(32'h03, 2'd1, 1'b0, 32'h0, 1'b0);
    tick();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("gs_moved_taken1", 32'(tk1), 32'h0);
    chk("gs_moved_target1", tgt1, 32'h03);
    tick();
    upd(32'h03, 2'd1, 1'b1, 32'hA0, 1'b0);
    tick(); tick();
    upd(32'h7F, 2'd0, 1'b1, 32'h5, 1'b1);
    tick();
    upd_valid = 1'b0; pred_pc = 32'h03;
    @(negedge clk);
    chk("gs_live_ghr1", 32'(gh1), 32'd1);
    chk("gs_live_target1", tgt1, 32'hA0);
    chk("gs_miss1", miss1, 32'd2);

    // mid-run reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_total0", tot0, 32'd0);
    chk("rst_miss1", miss1, 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'h0);
    chk("rst_ready1", 32'(rdy1), 32'h0);

    // random traffic, including a reset in the middle of the sweep
    repeat (100) begin tick(); rand_all(1'b0); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      tick();
      rand_all(1'b0);
      if (rdy0 && rdy1) break;
    end
    chk("rand_ready", 32'(rdy0 && rdy1), 32'h1);
    repeat (3000) begin tick(); rand_all(1'b1); end
    tick();
    set_idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
